eeprom_spi_capture: RTL and testbench
=====================================

Name: eeprom_spi_capture

Overview:
- Sits directly downstream of the EEPROM emulation core, on the same SClk domain.
- Consumes its serial write-back stream (SPIDo, SPISel, SPIClkRunning) and deserialises each framed transaction into a 16-bit command and a 16-bit data word.
- Classifies each frame as a write record or an erase record and queues it in a small FIFO.
- The flash persistence engine drains the FIFO over a valid/ready handshake, so emulated EEPROM writes survive power-off.

Parameters:
- FifoDepthLog2, 2, log2 of the record FIFO depth; default gives 4 entries.

Ports:
- SClk  input  1  system clock; all logic is on its rising edge.
- nReset  input  1  synchronous active-low reset.
- SPIDo  input  1  serial data from the EEPROM core, MSB first.
- SPISel  input  1  frame select, active low.
- SPIClkRunning  input  1  bit-valid qualifier.
- ClearFlags  input  1  one-cycle pulse; clears sticky flags.
- RecValid  output  1  FIFO head record is valid.
- RecReady  input  1  consumer accepts the head record.
- RecCommand  output  16  head record command word.
- RecData  output  16  head record data word; 16'hFFFF for erase records.
- RecIsErase  output  1  1 = erase-type record (16-bit frame), 0 = write-type record (32-bit frame).
- Overflow  output  1  sticky: a good frame was dropped because the FIFO was full.
- FrameError  output  1  sticky: a frame closed with a bit count other than 16 or 32.
- Busy  output  1  a frame is currently being shifted in.

Behaviour:
- Reset, while nReset is low at a clock edge:
  - FSM goes to IDLE; shift register and bit counter clear to 0.
  - FIFO is emptied (RecValid=0). RecCommand, RecData and RecIsErase read 0.
  - Overflow=0, FrameError=0, Busy=0.
  - A frame in progress is discarded and not recorded.
- Bit sampling rule: one bit is taken on a rising edge when SPISel==0 and SPIClkRunning==1. The 32-bit shift register shifts left and SPIDo enters at bit 0.
- The bit counter is 6 bits wide and saturates at 33. Any count of 33 means "overlength".
- FSM states and transitions:
  - IDLE: Busy=0. When SPISel==0, go to SHIFT and clear the counter. If SPIClkRunning==1 on that same edge, that bit is captured and the counter becomes 1.
  - SHIFT: Busy=1. Sample bits per the sampling rule. When SPISel==1, go to COMMIT. No bit is taken on the edge where SPISel is high.
  - COMMIT: one cycle, Busy=0. Classify the frame, then return to IDLE. If SPISel is already low again, go straight to SHIFT instead.
- Classification in COMMIT:
  - Count == 16: erase record. Command = shift[15:0], Data = 16'hFFFF, IsErase = 1.
  - Count == 32: write record. Command = shift[31:16], Data = shift[15:0], IsErase = 0.
  - Any other count, including 0 and 33: no record is pushed and FrameError is set.
- Push rules:
  - A classified record is pushed when the FIFO is not full.
  - If the FIFO is full, the record is dropped and Overflow is set. Existing entries are never overwritten.
- FIFO behaviour:
  - First-word-fall-through. RecValid rises the cycle after the push edge, so latency is 1 cycle from COMMIT.
  - Pop happens on an edge where RecValid && RecReady.
  - A simultaneous push and pop while full is allowed: the pop frees the slot and the push succeeds, with no overflow.
  - Pointers are FifoDepthLog2+1 bits and wrap naturally. Full is detected when the MSBs differ and the low bits are equal.
  - RecCommand, RecData and RecIsErase hold stable while RecValid && !RecReady.
- Sticky flags:
  - ClearFlags clears Overflow and FrameError.
  - If a set event and ClearFlags occur on the same edge, the set wins.

Optional Feature:
- Macro: EEPROM_SPI_CAPTURE_DROPCOUNT_EN.
- When defined:
  - Extra output DropCount, 8 bits, reset to 0.
  - It increments on each dropped good frame (overflow) and each FrameError event, saturating at 8'hFF.
  - ClearFlags zeroes it; an increment on the same edge as ClearFlags wins.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- 32-bit frame: command 16'h14A5, data 16'hBEEF sent MSB first with SPISel low and 32 qualified bits. Expect RecValid one cycle after COMMIT with RecCommand=14A5, RecData=BEEF, RecIsErase=0.
- 16-bit frame: command 16'h1C07. Expect RecCommand=1C07, RecData=FFFF, RecIsErase=1.
- FIFO full: push 5 frames with RecReady=0 and depth 4. Expect 4 records in order, Overflow=1 after the 5th, and DropCount=1 when the macro is defined.
- Pop while full: the 5th frame's COMMIT coincides with a RecReady=1 pop. Expect no overflow and the 5th record last in order.
- Malformed frames: a 20-bit frame, then a 40-bit frame. Expect no push, FrameError=1, DropCount=2 when the macro is defined. Then ClearFlags clears the flag and the count.
- Reset mid-frame: nReset=0 after 10 bits, then a clean 32-bit frame 0x1400/0x1234. Expect exactly one record 1400/1234 and no FrameError.

Source files
------------

// File: rtl/eeprom_spi_capture.sv
// eeprom_spi_capture: deserialises EEPROM write-back SPI frames into
// write/erase records and queues them in a FWFT FIFO for the flash engine.
//
// Ports:
//   SClk, nReset          clock, synchronous active-low reset
//   SPIDo, SPISel,        serial stream from the EEPROM core (MSB first,
//   SPIClkRunning         SPISel active low, SPIClkRunning qualifies bits)
//   ClearFlags            clears Overflow / FrameError (and DropCount)
//   RecValid, RecReady    record handshake toward the persistence engine
//   RecCommand, RecData,  head record contents
//   RecIsErase
//   Overflow, FrameError  sticky status flags
//   Busy                  a frame is being shifted in
//   DropCount             only with EEPROM_SPI_CAPTURE_DROPCOUNT_EN defined
module eeprom_spi_capture #(
    parameter int FifoDepthLog2 = 2
) (
    input  logic        SClk,
    input  logic        nReset,
    input  logic        SPIDo,
    input  logic        SPISel,
    input  logic        SPIClkRunning,
    input  logic        ClearFlags,
    output logic        RecValid,
    input  logic        RecReady,
    output logic [15:0] RecCommand,
    output logic [15:0] RecData,
    output logic        RecIsErase,
    output logic        Overflow,
    output logic        FrameError,
    output logic        Busy
`ifdef EEPROM_SPI_CAPTURE_DROPCOUNT_EN
    ,
    output logic [7:0]  DropCount
`endif
);

    localparam int Depth = 1 << FifoDepthLog2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [5:0] CntSat = 6'd33;

    logic [1:0]  state;
    logic [31:0] shift_q;
    logic [5:0]  bit_cnt;
    logic        take_bit;

    assign take_bit = !SPISel && SPIClkRunning;

    // COMMIT behaves like IDLE for frame start, so back-to-back frames
    // lose no bits.
    always_ff @(posedge SClk) begin
        if (!nReset) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                IDLE, COMMIT: begin
                    if (!SPISel) begin
                        state   <= SHIFT;
                        bit_cnt <= take_bit ? 6'd1 : 6'd0;
                        if (take_bit)
                            shift_q <= {shift_q[30:0], SPIDo};
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (SPISel) begin
                        state <= COMMIT;
                    end else if (take_bit) begin
                        shift_q <= {shift_q[30:0], SPIDo};
                        if (bit_cnt != CntSat)
                            bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy = (state == SHIFT);

    logic        commit;
    logic        frame_erase;
    logic        frame_write;
    logic        rec_good;
    logic        ferr_set;
    logic [15:0] rec_cmd;
    logic [15:0] rec_data;

    assign commit      = (state == COMMIT);
    assign frame_erase = (bit_cnt == 6'd16);
    assign frame_write = (bit_cnt == 6'd32);
    assign rec_good    = commit && (frame_erase || frame_write);
    assign ferr_set    = commit && !(frame_erase || frame_write);
    assign rec_cmd     = frame_write ? shift_q[31:16] : shift_q[15:0];
    assign rec_data    = frame_write ? shift_q[15:0] : 16'hFFFF;

    logic [FifoDepthLog2:0]   wr_ptr;
    logic [FifoDepthLog2:0]   rd_ptr;
    logic [FifoDepthLog2-1:0] wr_idx;
    logic [FifoDepthLog2-1:0] rd_idx;
    logic [15:0]              cmd_mem [Depth];
    logic [15:0]              data_mem[Depth];
    logic                     erase_mem[Depth];
    logic                     empty;
    logic                     full;
    logic                     pop;
    logic                     push;
    logic                     ovf_set;

    assign wr_idx = wr_ptr[FifoDepthLog2-1:0];
    assign rd_idx = rd_ptr[FifoDepthLog2-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[FifoDepthLog2] != rd_ptr[FifoDepthLog2]) &&
                    (wr_idx == rd_idx);
    assign pop    = RecValid && RecReady;
    // A pop on the same edge frees the slot the push needs.
    assign push    = rec_good && (!full || pop);
    assign ovf_set = rec_good && full && !pop;

    always_ff @(posedge SClk) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge SClk) begin
        if (push) begin
            cmd_mem[wr_idx]   <= rec_cmd;
            data_mem[wr_idx]  <= rec_data;
            erase_mem[wr_idx] <= frame_erase;
        end
    end

    assign RecValid   = !empty;
    assign RecCommand = RecValid ? cmd_mem[rd_idx] : 16'h0000;
    assign RecData    = RecValid ? data_mem[rd_idx] : 16'h0000;
    assign RecIsErase = RecValid ? erase_mem[rd_idx] : 1'b0;

    // Set has priority over ClearFlags.
    always_ff @(posedge SClk) begin
        if (!nReset) begin
            Overflow   <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            if (ovf_set)
                Overflow <= 1'b1;
            else if (ClearFlags)
                Overflow <= 1'b0;
            if (ferr_set)
                FrameError <= 1'b1;
            else if (ClearFlags)
                FrameError <= 1'b0;
        end
    end

`ifdef EEPROM_SPI_CAPTURE_DROPCOUNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge SClk) begin
        if (!nReset) begin
            drop_cnt <= 8'h00;
        end else if (ovf_set || ferr_set) begin
            if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'h01;
        end else if (ClearFlags) begin
            drop_cnt <= 8'h00;
        end
    end

    assign DropCount = drop_cnt;
`endif

endmodule

// File: tb/tb_eeprom_spi_capture.sv
// tb_eeprom_spi_capture: directed and randomized frames checked every
// cycle against a frame-level queue model, plus literal spot checks.
module tb_eeprom_spi_capture;

    localparam int DEPTH = 4;

    logic        SClk = 1'b0;
    logic        nReset = 1'b0;
    logic        SPIDo = 1'b0;
    logic        SPISel = 1'b1;
    logic        SPIClkRunning = 1'b0;
    logic        ClearFlags = 1'b0;
    logic        RecValid;
    logic        RecReady = 1'b0;
    logic [15:0] RecCommand;
    logic [15:0] RecData;
    logic        RecIsErase;
    logic        Overflow;
    logic        FrameError;
    logic        Busy;
`ifdef EEPROM_SPI_CAPTURE_DROPCOUNT_EN
    logic [7:0]  DropCount;
`endif

    eeprom_spi_capture #(.FifoDepthLog2(2)) dut (
        .SClk(SClk),
        .nReset(nReset),
        .SPIDo(SPIDo),
        .SPISel(SPISel),
        .SPIClkRunning(SPIClkRunning),
        .ClearFlags(ClearFlags),
        .RecValid(RecValid),
        .RecReady(RecReady),
        .RecCommand(RecCommand),
        .RecData(RecData),
        .RecIsErase(RecIsErase),
        .Overflow(Overflow),
        .FrameError(FrameError),
        .Busy(Busy)
`ifdef EEPROM_SPI_CAPTURE_DROPCOUNT_EN
        ,
        .DropCount(DropCount)
`endif
    );

    always #5 SClk = ~SClk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Frame-level model: a frame is a run of SPISel-low edges; it is
    // judged one edge after SPISel returns high.
    typedef struct {
        logic [15:0] c;
        logic [15:0] d;
        logic        e;
    } rec_t;

    rec_t        mq[$];
    int          m_n = 0;
    logic [31:0] m_val = '0;
    bit          m_in = 0;
    bit          m_pend = 0;
    bit          m_ovf = 0;
    bit          m_ferr = 0;
    int          m_drop = 0;
    bit          m_popd;
    bit          m_have;
    bit          m_ovf_ev;
    bit          m_ferr_ev;
    rec_t        m_r;

    always @(posedge SClk) begin
        if (!nReset) begin
            mq.delete();
            m_in = 0;
            m_pend = 0;
            m_n = 0;
            m_ovf = 0;
            m_ferr = 0;
            m_drop = 0;
        end else begin
            m_popd = RecReady && (mq.size() > 0);
            m_have = 0;
            m_ovf_ev = 0;
            m_ferr_ev = 0;
            if (m_pend) begin
                if (m_n == 16) begin
                    m_r.c = m_val[15:0];
                    m_r.d = 16'hFFFF;
                    m_r.e = 1'b1;
                    m_have = 1;
                end else if (m_n == 32) begin
                    m_r.c = m_val[31:16];
                    m_r.d = m_val[15:0];
                    m_r.e = 1'b0;
                    m_have = 1;
                end else begin
                    m_ferr_ev = 1;
                end
            end
            if (m_popd)
                void'(mq.pop_front());
            if (m_have) begin
                if (mq.size() < DEPTH)
                    mq.push_back(m_r);
                else
                    m_ovf_ev = 1;
            end
            m_ovf  = m_ovf_ev ? 1'b1 : (ClearFlags ? 1'b0 : m_ovf);
            m_ferr = m_ferr_ev ? 1'b1 : (ClearFlags ? 1'b0 : m_ferr);
            if (m_ovf_ev || m_ferr_ev)
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else if (ClearFlags)
                m_drop = 0;
            m_pend = m_in && SPISel;
            if (!SPISel) begin
                if (!m_in) begin
                    m_in = 1;
                    m_n = 0;
                end
                if (SPIClkRunning) begin
                    m_n++;
                    m_val = {m_val[30:0], SPIDo};
                end
            end else begin
                m_in = 0;
            end
        end
    end

    always @(negedge SClk) begin
        if (chk_en) begin
            check("valid", RecValid, mq.size() > 0);
            if (mq.size() > 0) begin
                check("cmd", RecCommand, mq[0].c);
                check("data", RecData, mq[0].d);
                check("erase", RecIsErase, mq[0].e);
            end else begin
                check("cmd_idle", RecCommand, 0);
                check("data_idle", RecData, 0);
                check("erase_idle", RecIsErase, 0);
            end
            check("overflow", Overflow, m_ovf);
            check("frameerr", FrameError, m_ferr);
            check("busy", Busy, m_in);
`ifdef EEPROM_SPI_CAPTURE_DROPCOUNT_EN
            check("dropcount", DropCount, m_drop);
`endif
        end
    end

    task automatic bitc(input logic b);
        @(negedge SClk);
        SPISel = 1'b0;
        SPIClkRunning = 1'b1;
        SPIDo = b;
    endtask

    task automatic send(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            bitc(v[i]);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge SClk);
            SPISel = 1'b1;
            SPIClkRunning = 1'b0;
        end
    endtask

    task automatic pop1();
        @(negedge SClk);
        RecReady = 1'b1;
        @(negedge SClk);
        RecReady = 1'b0;
    endtask

    task automatic clear1();
        @(negedge SClk);
        ClearFlags = 1'b1;
        @(negedge SClk);
        ClearFlags = 1'b0;
    endtask

    task automatic drain(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge SClk);
            check("order", RecCommand, first + 16'(i));
            RecReady = 1'b1;
        end
        @(negedge SClk);
        RecReady = 1'b0;
        check("drained", RecValid, 0);
    endtask

    task automatic rnd_cycle(input logic sel, input logic run);
        @(negedge SClk);
        SPISel = sel;
        SPIClkRunning = run;
        SPIDo = 1'($urandom);
        RecReady = ($urandom_range(0, 2) != 0);
        ClearFlags = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        @(posedge SClk);
        @(negedge SClk);
        chk_en = 1'b1;
        check("rst_valid", RecValid, 0);
        check("rst_busy", Busy, 0);
        nReset = 1'b1;

        // 32-bit write frame and its one-cycle latency
        send({32'h14A5_BEEF}, 32);
        gap(2);
        check("t1_busy", Busy, 0);
        check("t1_latency", RecValid, 0);
        gap(1);
        check("t1_valid", RecValid, 1);
        check("t1_cmd", RecCommand, 32'h14A5);
        check("t1_data", RecData, 32'hBEEF);
        check("t1_erase", RecIsErase, 0);
        pop1();

        // 16-bit erase frame
        send({48'h0, 16'h1C07}, 16);
        gap(3);
        check("t2_cmd", RecCommand, 32'h1C07);
        check("t2_data", RecData, 32'hFFFF);
        check("t2_erase", RecIsErase, 1);
        pop1();

        // five frames into a four-deep FIFO
        for (int i = 0; i < 5; i++) begin
            send({32'h0, 16'h1001 + 16'(i), 16'hA000 + 16'(i)}, 32);
            gap(3);
        end
        check("t3_ovf", Overflow, 1);
        check("t3_head", RecCommand, 32'h1001);
`ifdef EEPROM_SPI_CAPTURE_DROPCOUNT_EN
        check("t3_drop", DropCount, 1);
`endif
        drain(16'h1001, 4);
        clear1();
        check("t3_clr", Overflow, 0);

        // fifth COMMIT coincides with a pop
        for (int i = 0; i < 4; i++) begin
            send({32'h0, 16'h2001 + 16'(i), 16'h5A5A}, 32);
            gap(3);
        end
        send({32'h0, 16'h2005, 16'h5A5A}, 32);
        @(negedge SClk);
        SPISel = 1'b1;
        SPIClkRunning = 1'b0;
        @(negedge SClk);
        RecReady = 1'b1;
        @(negedge SClk);
        RecReady = 1'b0;
        check("t4_noovf", Overflow, 0);
        drain(16'h2002, 4);

        // malformed frames
        send(64'h000A_BCDE, 20);
        gap(3);
        send(64'h12_3456_789A, 40);
        gap(3);
        check("t5_nopush", RecValid, 0);
        check("t5_ferr", FrameError, 1);
`ifdef EEPROM_SPI_CAPTURE_DROPCOUNT_EN
        check("t5_drop", DropCount, 2);
`endif
        clear1();
        check("t5_clr", FrameError, 0);
`ifdef EEPROM_SPI_CAPTURE_DROPCOUNT_EN
        check("t5_dropclr", DropCount, 0);
`endif

        // reset mid-frame
        send(64'h3FF, 10);
        @(negedge SClk);
        nReset = 1'b0;
        SPISel = 1'b1;
        SPIClkRunning = 1'b0;
        @(negedge SClk);
        @(negedge SClk);
        nReset = 1'b1;
        send({32'h1400_1234}, 32);
        gap(3);
        check("t6_cmd", RecCommand, 32'h1400);
        check("t6_data", RecData, 32'h1234);
        check("t6_ferr", FrameError, 0);
        pop1();
        gap(2);
        check("t6_one", RecValid, 0);

        // randomized traffic
        for (int f = 0; f < 150; f++) begin
            int len;
            int sent;
            int r;
            r = $urandom_range(0, 9);
            len = (r < 4) ? 16 : (r < 8) ? 32 : $urandom_range(0, 40);
            sent = 0;
            if (len == 0)
                rnd_cycle(1'b0, 1'b0);
            while (sent < len) begin
                if ($urandom_range(0, 3) != 0) begin
                    rnd_cycle(1'b0, 1'b1);
                    sent++;
                end else begin
                    rnd_cycle(1'b0, 1'b0);
                end
            end
            for (int g = $urandom_range(1, 4); g > 0; g--)
                rnd_cycle(1'b1, 1'b0);
            if ($urandom_range(0, 39) == 0) begin
                @(negedge SClk);
                nReset = 1'b0;
                @(negedge SClk);
                nReset = 1'b1;
            end
        end

        @(negedge SClk);
        RecReady = 1'b0;
        ClearFlags = 1'b0;
        repeat (3) @(negedge SClk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
